// File: rtl/gray_pack_pkg.sv
// Shared widths, FIFO entry layout and lane helper for the grayscale pixel packer.
package gray_pack_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } pack_entry_t;

  // Little-endian lane placement: lane 0 occupies bits [7:0].
  function automatic logic [WORD_W-1:0] lane_insert(
    input logic [WORD_W-1:0] acc,
    input logic [1:0]        lane,
    input logic [PIX_W-1:0]  pix
  );
    logic [WORD_W-1:0] r;
    r = acc;
    r[lane*PIX_W +: PIX_W] = pix;
    return r;
  endfunction

endpackage

// File: rtl/gray_pack_fifo.sv
// Synchronous show-ahead FIFO of packed words; head reads as zero while empty.
module gray_pack_fifo
  import gray_pack_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  pack_entry_t push_entry,
  input  logic        pop,
  output pack_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pack_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gray_pixel_packer.sv
// Packs 8-bit grayscale pixels four per 32-bit word with end-of-line flag.
// Optional GRAY_PIXEL_PACKER_DROPCNT_EN adds a saturating DROP_CNT output.
module gray_pixel_packer
  import gray_pack_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FRAME_START,
  input  logic              WREN,
  input  logic [PIX_W-1:0]  IN_PIX,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WORD_W-1:0] OUT_DATA,
  output logic              OUT_LAST,
  output logic              OVERFLOW
`ifdef GRAY_PIXEL_PACKER_DROPCNT_EN
  ,
  output logic [15:0]       DROP_CNT
`endif
);

  localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);

  // Reset asserts immediately, releases two clocks later on a clean edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  logic [11:0]       x;
  logic [11:0]       cur_x;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] base_acc;
  logic [WORD_W-1:0] next_acc;
  logic              at_eol;
  logic              word_done;
  logic              push_valid;
  pack_entry_t       push_entry;
  pack_entry_t       head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  // FRAME_START makes a same-cycle pixel column 0 and drops any partial word.
  always_comb begin
    cur_x     = FRAME_START ? '0 : x;
    base_acc  = FRAME_START ? '0 : acc;
    next_acc  = lane_insert(base_acc, cur_x[1:0], IN_PIX);
    at_eol    = (cur_x == X_LAST);
    word_done = WREN && ((cur_x[1:0] == 2'd3) || at_eol);
  end

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      x          <= '0;
      acc        <= '0;
      push_valid <= 1'b0;
      push_entry <= '0;
    end else begin
      push_valid <= word_done;
      if (word_done) begin
        push_entry <= '{last: at_eol, data: next_acc};
      end
      if (WREN) begin
        x   <= at_eol ? 12'd0 : cur_x + 12'd1;
        acc <= word_done ? '0 : next_acc;
      end else if (FRAME_START) begin
        x   <= '0;
        acc <= '0;
      end
    end
  end

  gray_pack_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (rst_int_n),
    .push      (push_valid),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign OUT_VALID = !fifo_empty;
  assign OUT_DATA  = head.data;
  assign OUT_LAST  = head.last;
  assign pop       = OUT_VALID && OUT_READY;
  assign drop      = push_valid && fifo_full && !pop;

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      OVERFLOW <= 1'b0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
    end
  end

`ifdef GRAY_PIXEL_PACKER_DROPCNT_EN
  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      DROP_CNT <= '0;
    end else if (drop && (DROP_CNT != 16'hFFFF)) begin
      DROP_CNT <= DROP_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: doc/gray_pixel_packer.md
GRAY_PIXEL_PACKER -- requirements
Module: gray_pixel_packer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: pixels per line, range 1..4095.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: packed-word FIFO entries, power of two, 4..256.
REQ-003 SHALL have port CLK  input  1  single clock for all logic.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port FRAME_START  input  1  one-cycle pulse that resynchronises to pixel 0 of a frame.
REQ-006 SHALL have port WREN  input  1  pixel strobe from the grayscale stage.
REQ-007 SHALL have port IN_PIX  input  8  grayscale pixel, qualified by WREN.
REQ-008 SHALL have port OUT_VALID  output  1  packed word available.
REQ-009 SHALL have port OUT_READY  input  1  downstream accepts word.
REQ-010 SHALL have port OUT_DATA  output  32  four packed pixels.
REQ-011 SHALL have port OUT_LAST  output  1  word holds the last pixel of a line.
REQ-012 SHALL have port OVERFLOW  output  1  sticky: a word was dropped.

Function
REQ-013 SHALL keep a pixel column counter x (12 bits), +1 per WREN, wrapping IMG_WIDTH-1 -> 0.
REQ-014 SHALL place the pixel at x into accumulator lane x[1:0], bits [8*lane+7 : 8*lane] (little-endian).
REQ-015 SHALL complete a word when lane = 3 or x = IMG_WIDTH-1; unused lanes of a partial word SHALL be 0x00.
REQ-016 SHALL clear the accumulator after each completed word.
REQ-017 SHALL push each completed word with its LAST flag (1 iff x = IMG_WIDTH-1) into the FIFO in the cycle after the completing WREN.
REQ-018 SHALL show-ahead: with an empty FIFO, OUT_VALID rises 2 cycles after the completing WREN (1 cycle for the push, 1 for registered output).
REQ-019 SHALL hold OUT_DATA and OUT_LAST stable while OUT_VALID=1 and OUT_READY=0.
REQ-020 SHALL pop on OUT_VALID && OUT_READY; OUT_VALID = FIFO not empty.
REQ-021 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle.
REQ-022 SHALL drop a push when the FIFO is full with no pop, set OVERFLOW, and keep counting x.
REQ-023 SHALL let FRAME_START reset x to 0 and discard any partial accumulator; FRAME_START with WREN in the same cycle SHALL treat that pixel as x = 0.
REQ-024 SHALL leave FIFO contents and OVERFLOW unaffected by FRAME_START.
REQ-025 SHALL support continuous WREN every cycle without loss while OUT_READY = 1.

Reset
REQ-026 SHALL, on RST_N low, asynchronously clear x, the accumulator, the push stage, FIFO pointers and OVERFLOW.
REQ-027 SHALL drive OUT_VALID=0, OUT_DATA=0, OUT_LAST=0 and OVERFLOW=0 during reset.
REQ-028 SHALL discard a partial word on reset mid-line; the first WREN after release is x = 0.
REQ-029 SHALL use synchronous release and need no FRAME_START after reset.

Configuration
REQ-030 SHALL, with macro GRAY_PIXEL_PACKER_DROPCNT_EN defined, add output DROP_CNT (16 bits), counting dropped words, saturating at 0xFFFF, and cleared only by reset.
REQ-031 SHALL, without GRAY_PIXEL_PACKER_DROPCNT_EN, omit the DROP_CNT port and counter, leaving all other behaviour identical.

Structure
REQ-032 SHALL take PIX_W = 8, WORD_W = 32 and LANES = 4, and the FIFO entry struct {last, data[31:0]}, from shared package gray_pack_pkg.
REQ-033 SHALL implement the FIFO as sub-module gray_pack_fifo (synchronous, show-ahead, full/empty flags, parameter DEPTH).
REQ-034 SHALL keep the counter, accumulator and overflow logic in gray_pixel_packer.

Verification
REQ-035 SHALL cover: IMG_WIDTH=8; FRAME_START, then pixels 0x01..0x08 back-to-back; OUT_READY=1 -> words 0x04030201 (LAST=0) and 0x08070605 (LAST=1).
REQ-036 SHALL cover: IMG_WIDTH=6; pixels 0x11..0x16 -> words 0x14131211 (LAST=0) and 0x00001615 (LAST=1).
REQ-037 SHALL cover: FIFO_DEPTH=4; OUT_READY=0; 20 completed words -> 4 words retained, OVERFLOW=1, DROP_CNT=16 when the macro is set; then OUT_READY=1 -> the first 4 words are output in order.
REQ-038 SHALL cover: FIFO full; OUT_READY=1 in the same cycle as a push -> no drop and OVERFLOW stays 0.
REQ-039 SHALL cover: 3 pixels, then FRAME_START with WREN carrying 0xAA, then 0xBB, 0xCC, 0xDD -> next word 0xDDCCBBAA; the partial word is discarded.
REQ-040 SHALL cover: RST_N low mid-line with 2 words queued -> OUT_VALID=0 immediately; after release, pixels 0x01..0x04 -> 0x04030201.
